// File: rtl/mesh_egress_arbiter.sv
// mesh_egress_arbiter
//   Round-robin drain of the mesh terminal FIFOs into one registered
//   valid/ready stream. One-hot pop strobes are issued to the terminal
//   FIFOs. An optional burst allowance lets one terminal keep the grant
//   for up to BURST consecutive pops before the search rotates.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   enable     low blocks new pops; a held packet still drains
//   pndng      per-terminal FIFO head valid
//   data_out   per-terminal FIFO head, terminal i at [i*PCKG_SZ +: PCKG_SZ]
//   pop        one-hot pop strobe (combinational, no path from data_out)
//   m_valid    output register holds a packet
//   m_data     packet payload
//   m_src      source terminal index of the packet
//   m_ready    downstream accept
//   pkt_count  packets popped since reset, wraps modulo 2^32
module mesh_egress_arbiter #(
    parameter int ROWS    = 4,
    parameter int COLUMS  = 4,
    parameter int PCKG_SZ = 32,
    parameter int BURST   = 1,
    localparam int unsigned NTERM = ROWS * 2 + COLUMS * 2,
    localparam int IW = $clog2(NTERM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NTERM-1:0]         pndng,
    input  logic [NTERM*PCKG_SZ-1:0] data_out,
    output logic [NTERM-1:0]         pop,
    output logic                     m_valid,
    output logic [PCKG_SZ-1:0]       m_data,
    output logic [IW-1:0]            m_src,
    input  logic                     m_ready,
    output logic [31:0]              pkt_count
);

    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [IW-1:0] rr_ptr, rr_nx;
    logic [BW-1:0] burst_cnt, burst_nx;

    logic          can_accept;
    logic          allowed;
    logic          leave;
    logic          do_pop;
    logic [IW-1:0] gnt;
    logic [IW-1:0] base;
    logic [IW-1:0] pick;
    logic          found;

    assign can_accept = !m_valid || m_ready;
    assign allowed    = enable && can_accept && (|pndng);

    // A terminal leaving OWN is searched past, so it can only be re-picked last.
    assign base = (state == OWN) ? owner : rr_ptr;

    // Circular first-requester search starting at base+1.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= NTERM; k++) begin
            idx = 32'(base) + k;
            if (idx >= NTERM) begin
                idx = idx - NTERM;
            end
            if (!found && pndng[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        burst_nx = burst_cnt;
        rr_nx    = rr_ptr;
        do_pop   = 1'b0;
        gnt      = pick;
        leave    = 1'b0;

        case (state)
            OWN: begin
                if (pndng[owner] && (burst_cnt < BW'(BURST))) begin
                    if (allowed) begin
                        do_pop   = 1'b1;
                        gnt      = owner;
                        burst_nx = burst_cnt + 1'b1;
                    end
                end else if (!pndng[owner] || allowed) begin
                    // Owner ran dry or used its allowance: release and
                    // fall through to a fresh selection this same cycle.
                    leave    = 1'b1;
                    rr_nx    = owner;
                    state_nx = IDLE;
                end
            end
            default: leave = 1'b1;
        endcase

        if (leave && allowed && found) begin
            do_pop   = 1'b1;
            gnt      = pick;
            owner_nx = pick;
            burst_nx = BW'(1);
            if (BURST > 1) begin
                state_nx = OWN;
            end else begin
                rr_nx = pick;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (do_pop && !reset) begin
            pop[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= IW'(NTERM - 1);
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_src     <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            burst_cnt <= burst_nx;
            rr_ptr    <= rr_nx;
            if (do_pop) begin
                m_data    <= data_out[32'(gnt) * PCKG_SZ +: PCKG_SZ];
                m_src     <= gnt;
                m_valid   <= 1'b1;
                pkt_count <= pkt_count + 32'd1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mesh_egress_arbiter.sv
// Testbench for mesh_egress_arbiter: two instances (BURST=1 and BURST=4)
// each fed by their own set of modelled terminal FIFOs, compared every
// cycle against an owner/quota reference model, plus directed scenarios
// with hand-computed grant sequences.
module tb_mesh_egress_arbiter;

    localparam int NT = 16;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic reset, enable, m_ready;

    logic [NT-1:0]   pnd0, pnd1, pop0, pop1;
    logic [NT*W-1:0] dat0, dat1;
    logic            mv0, mv1;
    logic [W-1:0]    md0, md1;
    logic [3:0]      ms0, ms1;
    logic [31:0]     pc0, pc1;

    always #5 clk = ~clk;

    mesh_egress_arbiter #(.ROWS(4), .COLUMS(4), .PCKG_SZ(32), .BURST(1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .pndng(pnd0), .data_out(dat0),
        .pop(pop0), .m_valid(mv0), .m_data(md0), .m_src(ms0), .m_ready(m_ready),
        .pkt_count(pc0));

    mesh_egress_arbiter #(.ROWS(4), .COLUMS(4), .PCKG_SZ(32), .BURST(4)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .pndng(pnd1), .data_out(dat1),
        .pop(pop1), .m_valid(mv1), .m_data(md1), .m_src(ms1), .m_ready(m_ready),
        .pkt_count(pc1));

    // Terminal FIFOs: depth and the sequence number of the current head.
    int depth [2][NT];
    int seqn  [2][NT];

    // Reference model: current owner (-1 = none), pops used by the owner,
    // last terminal served (search restarts after it), expected outputs.
    int          owner [2];
    int          used  [2];
    int          last  [2];
    bit          emv   [2];
    logic [31:0] emd   [2];
    int          ems   [2];
    logic [31:0] ecnt  [2];
    int          blen  [2] = '{1, 4};

    int obs [2][$];
    int nvec = 0;
    int nbad = 0;

    function automatic logic [31:0] head(int k, int i);
        return {4'(k), 4'(i), 24'(seqn[k][i])};
    endfunction

    function automatic int obs_at(int k, int n);
        return (n < obs[k].size()) ? obs[k][n] : -1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; used[k] = 0; last[k] = NT - 1;
            emv[k] = 1'b0; emd[k] = '0; ems[k] = 0; ecnt[k] = '0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NT; i++) begin
            pnd0[i] = depth[0][i] > 0;
            pnd1[i] = depth[1][i] > 0;
            dat0[i*W +: W] = head(0, i);
            dat1[i*W +: W] = head(1, i);
        end
    endtask

    task automatic clear_fifos(int k);
        for (int i = 0; i < NT; i++) begin
            depth[k][i] = 0;
            seqn[k][i]  = 0;
        end
    endtask

    // One clock: drive FIFO heads, check every output of both instances
    // against the model, then advance model and FIFOs across the edge.
    task automatic cyc();
        int gn [2];
        int on [2];
        int un [2];
        int ln [2];
        drive();
        #1;
        if (reset) model_reset();
        for (int k = 0; k < 2; k++) begin
            bit any, allowed;
            int g, o, u, l;
            logic [NT-1:0] ep, ap;
            any = 1'b0;
            for (int i = 0; i < NT; i++) any |= depth[k][i] > 0;
            allowed = !reset && enable && (!emv[k] || m_ready) && any;
            g = -1; o = owner[k]; u = used[k]; l = last[k];
            if (o >= 0) begin
                if (depth[k][o] > 0 && u < blen[k]) begin
                    if (allowed) begin g = o; u++; end
                end else if (depth[k][o] == 0 || allowed) begin
                    l = o; o = -1;
                end
            end
            if (o < 0 && allowed) begin
                for (int s = 1; s <= NT; s++)
                    if (g < 0 && depth[k][(l + s) % NT] > 0) g = (l + s) % NT;
                o = g; u = 1;
                if (blen[k] == 1) begin l = g; o = -1; end
            end
            gn[k] = g; on[k] = o; un[k] = u; ln[k] = l;
            ep = '0;
            if (g >= 0) ep[g] = 1'b1;
            ap = (k == 0) ? pop0 : pop1;
            chk($sformatf("pop%0d", k), 32'(ap), 32'(ep));
            chk($sformatf("m_valid%0d", k), 32'((k == 0) ? mv0 : mv1), 32'(emv[k]));
            chk($sformatf("m_data%0d", k), (k == 0) ? md0 : md1, emd[k]);
            chk($sformatf("m_src%0d", k), 32'((k == 0) ? ms0 : ms1), 32'(ems[k]));
            chk($sformatf("pkt_count%0d", k), (k == 0) ? pc0 : pc1, ecnt[k]);
            for (int i = 0; i < NT; i++) if (ap[i]) obs[k].push_back(i);
        end
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                owner[k] = on[k]; used[k] = un[k]; last[k] = ln[k];
                if (gn[k] >= 0) begin
                    emv[k] = 1'b1;
                    emd[k] = head(k, gn[k]);
                    ems[k] = gn[k];
                    ecnt[k] = ecnt[k] + 32'd1;
                    depth[k][gn[k]]--;
                    seqn[k][gn[k]]++;
                end else if (emv[k] && m_ready) begin
                    emv[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int w9 [9] = '{2, 2, 2, 2, 9, 9, 9, 9, 2};
        int w4 [4] = '{2, 2, 9, 9};

        reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
        clear_fifos(0); clear_fifos(1);
        model_reset();
        drive();
        @(negedge clk);
        cyc();
        chk("rst_pkt_count", pc0, 32'd0);
        chk("rst_m_valid", 32'(mv1), 32'd0);
        chk("rst_pop", 32'(pop1), 32'd0);
        reset = 1'b0;
        cyc();

        // Single terminal, three packets 0xA..0xC.
        depth[0][5] = 3; seqn[0][5] = 10;
        obs[0].delete();
        repeat (5) cyc();
        for (int n = 0; n < 3; n++) chk("single_src", 32'(obs_at(0, n)), 32'd5);
        chk("single_count", 32'(obs[0].size()), 32'd3);
        chk("single_pkt_count", pc0, 32'd3);
        chk("single_last_data", md0, 32'h0500000C);

        // Fairness, all terminals pending, BURST=1.
        pulse_reset();
        for (int i = 0; i < NT; i++) depth[0][i] = 3;
        obs[0].delete();
        repeat (18) cyc();
        for (int n = 0; n < 18; n++) chk("fair_order", 32'(obs_at(0, n)), 32'(n % NT));

        // Burst of 4 alternating between terminals 2 and 9.
        pulse_reset();
        clear_fifos(0);
        depth[1][2] = 20; depth[1][9] = 20;
        obs[1].delete();
        repeat (9) cyc();
        for (int n = 0; n < 9; n++) chk("burst_order", 32'(obs_at(1, n)), 32'(w9[n]));

        // Burst cut short: terminal 2 holds only two packets.
        pulse_reset();
        clear_fifos(1);
        depth[1][2] = 2; depth[1][9] = 20;
        obs[1].delete();
        repeat (4) cyc();
        for (int n = 0; n < 4; n++) chk("cut_order", 32'(obs_at(1, n)), 32'(w4[n]));

        // Reset while terminal 7 owns the grant.
        clear_fifos(1);
        depth[1][7] = 10;
        repeat (2) cyc();
        depth[1][0] = 5;
        reset = 1'b1;
        cyc();
        chk("midrst_m_valid", 32'(mv1), 32'd0);
        chk("midrst_pkt_count", pc1, 32'd0);
        reset = 1'b0;
        obs[1].delete();
        cyc();
        chk("midrst_first", 32'(obs_at(1, 0)), 32'd0);

        // Back-pressure on a held packet from terminal 3.
        clear_fifos(0); clear_fifos(1);
        depth[0][3] = 4; seqn[0][3] = 32;
        cyc();
        m_ready = 1'b0;
        repeat (5) cyc();
        chk("bp_data", md0, 32'h03000020);
        chk("bp_valid", 32'(mv0), 32'd1);
        m_ready = 1'b1;
        cyc();

        // enable low: no pops, held packet drains on one m_ready.
        enable = 1'b0; m_ready = 1'b0;
        repeat (2) cyc();
        m_ready = 1'b1;
        cyc();
        chk("en_drain_valid", 32'(mv0), 32'd0);
        chk("en_no_pop_count", pc0, 32'd2);
        enable = 1'b1;

        // Randomised traffic, stalls, enable gaps and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            enable  = ($urandom % 8) != 0;
            m_ready = ($urandom % 4) != 0;
            for (int k = 0; k < 2; k++) begin
                if (($urandom % 4) == 0) begin
                    int t;
                    t = $urandom % NT;
                    depth[k][t] += $urandom_range(1, 4);
                end
            end
            reset = ($urandom % 300) == 0;
            cyc();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/mesh_egress_arbiter.md
Name: mesh_egress_arbiter

Overview:
Round-robin scheduler that drains the external terminal FIFOs of the mesh into one registered output stream. It watches every terminal's pndng/data_out pair and issues one-hot pop strobes, with an optional per-terminal burst allowance. Each packet is delivered on a valid/ready port together with its source terminal index. It sits between the mesh terminal outputs and the checker/scoreboard sink or a host port.

Parameters:
ROWS, 4, mesh rows
COLUMS, 4, mesh columns
PCKG_SZ, 32, packet width in bits
BURST, 1, max consecutive grants to one terminal before rotation (>=1)
NTERM, ROWS*2+COLUMS*2, derived localparam, number of terminals (16 at defaults)
IW, $clog2(NTERM), derived localparam, index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  when low, no new pops are issued
pndng  input  NTERM  per-terminal "FIFO head valid"
data_out  input  NTERM*PCKG_SZ  per-terminal FIFO head; terminal i occupies bits [i*PCKG_SZ +: PCKG_SZ]
pop  output  NTERM  one-hot pop strobe; at most one bit high
m_valid  output  1  output register holds a packet
m_data  output  PCKG_SZ  packet payload
m_src  output  IW  terminal index the packet came from
m_ready  input  1  downstream accepts when m_valid&&m_ready
pkt_count  output  32  total packets popped; wraps modulo 2^32

Behaviour:
- Reset (async assert): m_valid=0, m_data=0, m_src=0, pkt_count=0, FSM=IDLE, burst_cnt=0, rr_ptr=NTERM-1 (the first search starts at terminal 0). While reset is high, pop=0.
- can_accept = !m_valid || m_ready. A pop may be issued only when enable && can_accept && |pndng.
- pop is combinational from registered state plus pndng, enable, m_valid and m_ready. There is no combinational path from data_out to pop.
- FSM IDLE (no owner):
  - Select the first i with pndng[i]=1, searching circularly from rr_ptr+1.
  - If a pop is allowed: assert pop[i]; owner<=i; burst_cnt<=1.
  - Go to OWN if BURST>1, otherwise stay in IDLE with rr_ptr<=i.
- FSM OWN (locked owner):
  - If pndng[owner] && burst_cnt<BURST && a pop is allowed: assert pop[owner]; burst_cnt<=burst_cnt+1.
  - Leave to IDLE with rr_ptr<=owner when pndng[owner]=0, or when burst_cnt==BURST at a pop opportunity. In that same cycle, perform the IDLE selection. Owner stays excluded only if it is the sole requester? No: normal circular search from owner+1 applies, so owner can be re-selected last.
  - A stall (!can_accept or !enable) holds owner and burst_cnt unchanged.
- Capture on a pop cycle:
  - m_data<=data_out[sel]; m_src<=sel; m_valid<=1; pkt_count<=pkt_count+1.
  - data_out[sel] is sampled in the same cycle pop is high (FIFO head is valid while pndng is high).
- No-pop cycle with m_valid&&m_ready: m_valid<=0. m_data and m_src hold their last values.
- Latency and throughput: pop at cycle t gives m_valid at t+1. Sustained throughput is 1 packet/cycle with m_ready=1.
- Back-pressure: with m_valid=1 and m_ready=0, no pop is issued and m_data/m_src stay stable.
- enable low: pops stop; the held packet still drains; FSM state is kept.
- Reset mid-burst: everything returns to reset values; any held packet is discarded.

Test Plan:
- Single terminal: terminal 5 holds 3 packets (0xA,0xB,0xC), m_ready=1, BURST=1 -> pop[5] high on 3 consecutive cycles; m_src=5 and m_data=0xA,0xB,0xC on cycles t+1..t+3; pkt_count=3.
- Fairness: all 16 pndng high continuously, BURST=1 -> grant order 0,1,...,15,0,1; exactly one pop bit per cycle.
- Burst: BURST=4, terminals 2 and 9 pending continuously -> m_src sequence 2,2,2,2,9,9,9,9,2,...
- Burst cut short: BURST=4, terminal 2 drops pndng after its 2nd pop, terminal 9 pending -> next grant is 9 in the following cycle.
- Back-pressure: m_ready=0 for 5 cycles with m_valid=1 -> pop=0 and m_data stable; when m_ready=1, the next pop occurs the same cycle and m_valid stays 1.
- Reset mid-burst / enable low: reset asserted while owner=7 -> m_valid=0, pkt_count=0, next grant starts at terminal 0. enable=0 -> pop=0 and the held packet drains after one m_ready.
